// File: rtl/insn_encoder.sv
// insn_encoder: builds LEGv8 instruction words from opcode-class/field commands
// and streams them with byte write addresses towards instruction memory.
// The LI pseudo-op expands a 64-bit constant into MOVZ plus up to three MOVKs.
//
// Ports
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready      command handshake (in_op, in_rd, in_rn, in_rm, in_imm)
//   out_valid/out_ready    word handshake (out_insn, out_addr, out_last)
//   err                    one-cycle pulse when an accepted command is rejected
module insn_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [63:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_insn,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, EMIT, EXPAND} state_t;

  localparam logic [8:0] MOVZ_OP = 9'b110100101;
  localparam logic [8:0] MOVK_OP = 9'b111100101;

  state_t            state_q, state_d;
  logic [31:0]       insn_q, insn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [63:0]       const_q, const_d;
  logic [3:0]        mask_q, mask_d;
  logic [4:0]        rd_q, rd_d;

  logic              fire, accept;
  logic [ADDR_W-1:0] pc_adv;
  logic [31:0]       enc_insn;
  logic              enc_err, enc_li;
  logic [3:0]        hw_nz, li_mask, mask_nx;
  logic [1:0]        li_first, next_hw;
  logic              i_bad, sh_bad, d_bad, b_bad, cb_bad, mov_bad;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (m[i] && !found) begin
        idx   = i[1:0];
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  assign out_valid = (state_q != IDLE);
  assign out_insn  = insn_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;
  assign err       = err_q;

  assign in_ready = (state_q != EXPAND) && (!out_valid || (out_ready && last_q));
  assign fire     = out_valid && out_ready;
  assign accept   = in_valid && in_ready;
  assign pc_adv   = fire ? pc_q + ADDR_W'(4) : pc_q;

  // Range checks; signed fits are "all bits above the field equal".
  assign i_bad   = |in_imm[63:12];
  assign sh_bad  = |in_imm[63:6];
  assign d_bad   = !((in_imm[63:8] == '0) || (in_imm[63:8] == '1));
  assign b_bad   = (in_imm[1:0] != 2'b00) || !((in_imm[63:27] == '0) || (in_imm[63:27] == '1));
  assign cb_bad  = (in_imm[1:0] != 2'b00) || !((in_imm[63:20] == '0) || (in_imm[63:20] == '1));
  assign mov_bad = |in_imm[63:18];

  // LI: first word takes the lowest nonzero halfword; the rest go to the mask.
  assign hw_nz    = {|in_imm[63:48], |in_imm[47:32], |in_imm[31:16], |in_imm[15:0]};
  assign li_first = lowest_set(hw_nz);
  assign li_mask  = hw_nz & ~(4'b0001 << li_first);
  assign next_hw  = lowest_set(mask_q);
  assign mask_nx  = mask_q & ~(4'b0001 << next_hw);

  always_comb begin
    enc_insn = '0;
    enc_err  = 1'b0;
    enc_li   = 1'b0;
    case (in_op)
      5'd0:  enc_insn = {11'b10001011000, in_rm, 6'd0, in_rn, in_rd};
      5'd1:  enc_insn = {11'b11001011000, in_rm, 6'd0, in_rn, in_rd};
      5'd2:  enc_insn = {11'b10001010000, in_rm, 6'd0, in_rn, in_rd};
      5'd3:  enc_insn = {11'b10101010000, in_rm, 6'd0, in_rn, in_rd};
      5'd4:  enc_insn = {11'b11001010000, in_rm, 6'd0, in_rn, in_rd};
      5'd5:  enc_insn = {11'b10101011000, in_rm, 6'd0, in_rn, in_rd};
      5'd6:  enc_insn = {11'b11101011000, in_rm, 6'd0, in_rn, in_rd};
      5'd7:  enc_insn = {11'b11101010000, in_rm, 6'd0, in_rn, in_rd};
      5'd8:  begin enc_insn = {10'b1001000100, in_imm[11:0], in_rn, in_rd}; enc_err = i_bad; end
      5'd9:  begin enc_insn = {10'b1101000100, in_imm[11:0], in_rn, in_rd}; enc_err = i_bad; end
      5'd10: begin enc_insn = {10'b1001001000, in_imm[11:0], in_rn, in_rd}; enc_err = i_bad; end
      5'd11: begin enc_insn = {10'b1011001000, in_imm[11:0], in_rn, in_rd}; enc_err = i_bad; end
      5'd12: begin enc_insn = {10'b1101001000, in_imm[11:0], in_rn, in_rd}; enc_err = i_bad; end
      5'd13: begin enc_insn = {10'b1011000100, in_imm[11:0], in_rn, in_rd}; enc_err = i_bad; end
      5'd14: begin enc_insn = {10'b1111000100, in_imm[11:0], in_rn, in_rd}; enc_err = i_bad; end
      5'd15: begin enc_insn = {10'b1111001000, in_imm[11:0], in_rn, in_rd}; enc_err = i_bad; end
      5'd16: begin enc_insn = {11'b11010011011, 5'd0, in_imm[5:0], in_rn, in_rd}; enc_err = sh_bad; end
      5'd17: begin enc_insn = {11'b11010011010, 5'd0, in_imm[5:0], in_rn, in_rd}; enc_err = sh_bad; end
      5'd18: begin enc_insn = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd}; enc_err = d_bad; end
      5'd19: begin enc_insn = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd}; enc_err = d_bad; end
      5'd20: begin enc_insn = {6'b000101, in_imm[27:2]}; enc_err = b_bad; end
      5'd21: begin enc_insn = {6'b100101, in_imm[27:2]}; enc_err = b_bad; end
      5'd22: begin enc_insn = {8'b10110100, in_imm[20:2], in_rd}; enc_err = cb_bad; end
      5'd23: begin enc_insn = {8'b10110101, in_imm[20:2], in_rd}; enc_err = cb_bad; end
      5'd24: begin enc_insn = {MOVZ_OP, in_imm[17:16], in_imm[15:0], in_rd}; enc_err = mov_bad; end
      5'd25: begin enc_insn = {MOVK_OP, in_imm[17:16], in_imm[15:0], in_rd}; enc_err = mov_bad; end
      5'd26: begin
        enc_insn = {MOVZ_OP, li_first, in_imm[{li_first, 4'b0000} +: 16], in_rd};
        enc_li   = 1'b1;
      end
      default: enc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    insn_d  = insn_q;
    addr_d  = addr_q;
    last_d  = last_q;
    err_d   = 1'b0;
    const_d = const_q;
    mask_d  = mask_q;
    rd_d    = rd_q;
    pc_d    = pc_adv;
    case (state_q)
      EXPAND: begin
        if (fire) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            insn_d = {MOVK_OP, next_hw, const_q[{next_hw, 4'b0000} +: 16], rd_q};
            addr_d = pc_adv;
            mask_d = mask_nx;
            last_d = (mask_nx == 4'b0000);
          end
        end
      end
      default: begin
        if (accept) begin
          if (enc_err) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            insn_d = enc_insn;
            addr_d = pc_adv;
            if (enc_li && (li_mask != 4'b0000)) begin
              state_d = EXPAND;
              last_d  = 1'b0;
              const_d = in_imm;
              mask_d  = li_mask;
              rd_d    = in_rd;
            end else begin
              state_d = EMIT;
              last_d  = 1'b1;
            end
          end
        end else if (fire) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      insn_q  <= '0;
      addr_q  <= BASE_ADDR;
      pc_q    <= BASE_ADDR;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      const_q <= '0;
      mask_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      err_q   <= err_d;
      const_q <= const_d;
      mask_q  <= mask_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_insn_encoder.sv
// Scoreboard bench for insn_encoder: commands are scored by an arithmetic
// reference model when accepted; a monitor pops expected words on each fire.
module tb_insn_encoder;
  localparam int unsigned       ADDR_W = 32;
  localparam logic [ADDR_W-1:0] BASE   = '0;

  localparam int C_R = 0, C_SH = 1, C_I = 2, C_D = 3, C_B = 4, C_CB = 5, C_MV = 6, C_LI = 7, C_ILL = 8;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op, in_rd, in_rn, in_rm;
  logic [63:0]       in_imm;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_insn;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              err;

  insn_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .out_addr(out_addr), .out_last(out_last), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        last;
    logic        li;    // non-final word of a multi-word LI, or its final word
  } exp_t;

  exp_t            exp_q[$];
  int              exp_err = 0;
  int              checks = 0;
  int              errors = 0;
  longint unsigned model_pc = 0;
  int              rdy_mode = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic longint unsigned pw2(input int n);
    return 64'd1 << n;
  endfunction

  function automatic bit fits(input longint v, input int bits);
    longint lim;
    lim = longint'(64'd1 << (bits - 1));
    return (v >= -lim) && (v < lim);
  endfunction

  task automatic push(input longint unsigned w, input bit last, input bit li);
    exp_t e;
    e.insn = w[31:0];
    e.addr = model_pc[31:0];
    e.last = last;
    e.li   = li;
    exp_q.push_back(e);
    model_pc = (model_pc + 4) % pw2(32);
  endtask

  // Reference model: field placement by multiplication, range rules by value.
  task automatic model(input int op, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic [63:0] imm);
    longint          s;
    longint unsigned u, opc, w, q, rdv, rnv, rmv, hv;
    bit              ok;
    int              cls;
    int              hws[$];
    s = imm; u = imm; ok = 1'b1; w = 0; opc = 0; cls = C_ILL;
    rdv = 64'(rd); rnv = 64'(rn); rmv = 64'(rm);
    case (op)
      0:  begin cls = C_R;  opc = 64'b10001011000; end
      1:  begin cls = C_R;  opc = 64'b11001011000; end
      2:  begin cls = C_R;  opc = 64'b10001010000; end
      3:  begin cls = C_R;  opc = 64'b10101010000; end
      4:  begin cls = C_R;  opc = 64'b11001010000; end
      5:  begin cls = C_R;  opc = 64'b10101011000; end
      6:  begin cls = C_R;  opc = 64'b11101011000; end
      7:  begin cls = C_R;  opc = 64'b11101010000; end
      8:  begin cls = C_I;  opc = 64'b1001000100; end
      9:  begin cls = C_I;  opc = 64'b1101000100; end
      10: begin cls = C_I;  opc = 64'b1001001000; end
      11: begin cls = C_I;  opc = 64'b1011001000; end
      12: begin cls = C_I;  opc = 64'b1101001000; end
      13: begin cls = C_I;  opc = 64'b1011000100; end
      14: begin cls = C_I;  opc = 64'b1111000100; end
      15: begin cls = C_I;  opc = 64'b1111001000; end
      16: begin cls = C_SH; opc = 64'b11010011011; end
      17: begin cls = C_SH; opc = 64'b11010011010; end
      18: begin cls = C_D;  opc = 64'b11111000010; end
      19: begin cls = C_D;  opc = 64'b11111000000; end
      20: begin cls = C_B;  opc = 64'b000101; end
      21: begin cls = C_B;  opc = 64'b100101; end
      22: begin cls = C_CB; opc = 64'b10110100; end
      23: begin cls = C_CB; opc = 64'b10110101; end
      24: begin cls = C_MV; opc = 64'b110100101; end
      25: begin cls = C_MV; opc = 64'b111100101; end
      26: cls = C_LI;
      default: cls = C_ILL;
    endcase
    case (cls)
      C_R:  w = opc * pw2(21) + rmv * pw2(16) + rnv * 32 + rdv;
      C_SH: begin ok = (u < 64);   w = opc * pw2(21) + u * pw2(10) + rnv * 32 + rdv; end
      C_I:  begin ok = (u < 4096); w = opc * pw2(22) + u * pw2(10) + rnv * 32 + rdv; end
      C_D:  begin
        ok = (s >= -256) && (s <= 255);
        w  = opc * pw2(21) + (u % 512) * pw2(12) + rnv * 32 + rdv;
      end
      C_B:  begin
        ok = (s % 4 == 0) && fits(s / 4, 26);
        q  = longint'(s / 4);
        w  = opc * pw2(26) + (q % pw2(26));
      end
      C_CB: begin
        ok = (s % 4 == 0) && fits(s / 4, 19);
        q  = longint'(s / 4);
        w  = opc * pw2(24) + (q % pw2(19)) * 32 + rdv;
      end
      C_MV: begin
        ok = (u < pw2(18));
        w  = opc * pw2(23) + (u / 65536) * pw2(21) + (u % 65536) * 32 + rdv;
      end
      C_LI: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      exp_err++;
    end else if (cls != C_LI) begin
      push(w, 1'b1, 1'b0);
    end else begin
      for (int h = 0; h < 4; h++)
        if ((u / pw2(16 * h)) % 65536 != 0) hws.push_back(h);
      if (hws.size() == 0) begin
        push(64'b110100101 * pw2(23) + rdv, 1'b1, 1'b0);
      end else begin
        for (int i = 0; i < hws.size(); i++) begin
          opc = (i == 0) ? 64'b110100101 : 64'b111100101;
          hv  = (u / pw2(16 * hws[i])) % 65536;
          w   = opc * pw2(23) + 64'(hws[i]) * pw2(21) + hv * 32 + rdv;
          push(w, (i == hws.size() - 1), (hws.size() > 1));
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor
  logic        stall_pending = 1'b0;
  logic [31:0] held_insn;
  logic [32:0] held_al;
  exp_t        m_e;

  always @(negedge clk) begin
    if (reset) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_insn", 64'(out_insn), 64'(held_insn));
        check("hold_addr_last", 64'({out_addr, out_last}), 64'(held_al));
      end
      stall_pending = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(out_insn), 64'hDEAD_0000_0000_0000);
        end else begin
          m_e = exp_q[0];
          check("in_ready_busy", 64'(in_ready), 64'(m_e.last && !m_e.li && out_ready));
          if (out_ready) begin
            m_e = exp_q.pop_front();
            check("insn", 64'(out_insn), 64'(m_e.insn));
            check("addr", 64'(out_addr), 64'(m_e.addr));
            check("last", 64'(out_last), 64'(m_e.last));
          end else begin
            stall_pending = 1'b1;
            held_insn     = out_insn;
            held_al       = {out_addr, out_last};
          end
        end
      end else begin
        check("in_ready_idle", 64'(in_ready), 64'd1);
      end
      if (err) begin
        check("err_expected", 64'(exp_err > 0), 64'd1);
        if (exp_err > 0) exp_err--;
      end
    end
  end

  // Driver: call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int op, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [63:0] imm);
    int n;
    n = 0;
    in_op = 5'(op); in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    model(op, rd, rn, rm, imm);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_imm();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'($urandom_range(0, 4200));
      1: v = -64'($urandom_range(0, 300));
      2: v = {$urandom, $urandom};
      3: v = 64'($urandom_range(0, 80));
      4: v = (64'($urandom_range(0, 1 << 21)) - 64'(1 << 20)) << 2;
      5: v = (64'($urandom_range(0, 1 << 27)) - 64'(1 << 26)) << 2;
      6: v = 64'($urandom_range(0, 1 << 19));
      default: begin
        v = {$urandom, $urandom};
        for (int h = 0; h < 4; h++)
          if ($urandom_range(0, 1) == 0) v[16*h +: 16] = 16'h0000;
      end
    endcase
    return v;
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0;
    in_op = '0; in_rd = '0; in_rn = '0; in_rm = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_insn", 64'(out_insn), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'(BASE));
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    model_pc = 64'(BASE);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed commands, back to back
    send(0, 5'd1, 5'd2, 5'd3, 64'd0);
    send(8, 5'd9, 5'd9, 5'd0, 64'd1);
    send(8, 5'd9, 5'd9, 5'd0, 64'd4096);
    send(8, 5'd9, 5'd9, 5'd0, 64'd4095);
    send(26, 5'd0, 5'd0, 5'd0, 64'h0000_1234_0000_5678);
    send(22, 5'd5, 5'd0, 5'd0, -64'd8);
    send(22, 5'd5, 5'd0, 5'd0, -64'd6);
    send(16, 5'd4, 5'd6, 5'd0, 64'd63);
    send(17, 5'd4, 5'd6, 5'd0, 64'd64);
    send(18, 5'd7, 5'd8, 5'd0, -64'd256);
    send(18, 5'd7, 5'd8, 5'd0, -64'd257);
    send(19, 5'd7, 5'd8, 5'd0, 64'd255);
    send(19, 5'd7, 5'd8, 5'd0, 64'd256);
    send(20, 5'd0, 5'd0, 5'd0, 64'd134217724);
    send(20, 5'd0, 5'd0, 5'd0, 64'd134217728);
    send(21, 5'd0, 5'd0, 5'd0, -64'd134217728);
    send(21, 5'd0, 5'd0, 5'd0, -64'd134217732);
    send(23, 5'd2, 5'd0, 5'd0, 64'd1048572);
    send(23, 5'd2, 5'd0, 5'd0, 64'd1048576);
    send(24, 5'd3, 5'd0, 5'd0, 64'h3FFFF);
    send(25, 5'd3, 5'd0, 5'd0, 64'h40000);
    send(26, 5'd11, 5'd0, 5'd0, 64'd0);
    send(27, 5'd0, 5'd0, 5'd0, 64'd0);
    send(0, 5'd1, 5'd1, 5'd1, 64'd0);
    wait_drain();

    // Consumer stalls during an LI expansion
    rdy_mode = 2;
    send(26, 5'd12, 5'd0, 5'd0, 64'hABCD_0000_1111_0000);
    repeat (3) @(posedge clk);
    #1;
    rdy_mode = 1;
    wait_drain();

    // Reset in the middle of an expansion
    rdy_mode = 2;
    send(26, 5'd3, 5'd0, 5'd0, 64'h1111_2222_3333_4444);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    exp_err  = 0;
    model_pc = 64'(BASE);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_addr", 64'(out_addr), 64'(BASE));
    check("midrst_out_last", 64'(out_last), 64'd0);
    @(posedge clk); #1;
    reset    = 1'b0;
    rdy_mode = 1;
    @(posedge clk); #1;
    send(1, 5'd4, 5'd5, 5'd6, 64'd0);
    wait_drain();

    // Randomized traffic with random consumer back-pressure
    rdy_mode = 0;
    for (int k = 0; k < 300; k++)
      send($urandom_range(0, 31), 5'($urandom), 5'($urandom), 5'($urandom), rand_imm());
    rdy_mode = 1;
    wait_drain();

    check("pending_words", 64'(exp_q.size()), 64'd0);
    check("pending_err", 64'(exp_err), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
